// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks an active-low column drive across the matrix,
// debounces whole frames and reports a single held key as ready/keycode/press.
module keypad_scanner #(
    parameter int COLS           = 4,
    parameter int ROWS           = 5,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic [4:0]      keycode,
    output logic            ready,
    output logic            press
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);
    localparam logic [COLS-1:0]  COL_ONE = COLS'(1);
    localparam logic [1:0] K_NONE = 2'd0, K_SINGLE = 2'd1, K_MULTI = 2'd2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_EVAL = 2'd2} state_t;
    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] code;
    } result_t;

    logic [ROWS-1:0]  row_meta_q, row_sync_q, row_hit;
    state_t           state_q, state_d;
    logic [COL_W-1:0] col_idx_q, col_idx_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic [4:0]       acc_code_q, acc_code_d;
    result_t          frame_res, cand_q, cand_d, stable_q, stable_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [COLS-1:0]  col_n_q, col_n_d;
    logic [4:0]       keycode_q, keycode_d;
    logic             ready_q, ready_d, press_q, press_d;
    logic             last_settle, last_col;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row_hit
            assign row_hit[gi] = ~row_sync_q[gi];
        end
    endgenerate

    assign last_settle = (settle_q == SET_W'(SETTLE_CYCLES - 1));
    assign last_col    = (col_idx_q == COL_W'(COLS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            state_q    <= S_IDLE;
            col_idx_q  <= '0;
            settle_q   <= '0;
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
            cand_q     <= '0;
            deb_cnt_q  <= '0;
            stable_q   <= '0;
            col_n_q    <= '1;
            keycode_q  <= '0;
            ready_q    <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            settle_q   <= settle_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            cand_q     <= cand_d;
            deb_cnt_q  <= deb_cnt_d;
            stable_q   <= stable_d;
            col_n_q    <= col_n_d;
            keycode_q  <= keycode_d;
            ready_q    <= ready_d;
            press_q    <= press_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        settle_d  = settle_q;
        case (state_q)
            S_IDLE, S_EVAL: begin
                state_d   = S_DRIVE;
                col_idx_d = '0;
                settle_d  = '0;
            end
            S_DRIVE: begin
                if (last_settle) begin
                    settle_d = '0;
                    if (last_col) state_d = S_EVAL;
                    else          col_idx_d = col_idx_q + 1'b1;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Column drive is registered from the next state so it always lines up with state_q.
    always_comb begin
        col_n_d = '1;
        if (state_d == S_DRIVE) col_n_d = ~(COL_ONE << col_idx_d);
    end

    always_comb begin
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (state_q == S_EVAL) begin
            acc_cnt_d  = '0;
            acc_code_d = '0;
        end else if (state_q == S_DRIVE && last_settle) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_hit[r]) begin
                    acc_cnt_d  = (acc_cnt_d == 2'd0) ? 2'd1 : 2'd2;
                    acc_code_d = 5'(r * COLS) + 5'(col_idx_q);
                end
            end
        end
    end

    always_comb begin
        frame_res = '0;
        if (acc_cnt_q == 2'd1) begin
            frame_res.kind = K_SINGLE;
            frame_res.code = acc_code_q;
        end else if (acc_cnt_q != 2'd0) begin
            frame_res.kind = K_MULTI;
        end
    end

    // A differing frame restarts the count; a stable result only appears after
    // DEBOUNCE_SCANS identical frames in a row.
    always_comb begin
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        stable_d  = stable_q;
        press_d   = 1'b0;
        ready_d   = ready_q;
        keycode_d = keycode_q;
        if (state_q == S_EVAL) begin
            if (frame_res == cand_q) begin
                if (deb_cnt_q != DEB_MAX) deb_cnt_d = deb_cnt_q + 1'b1;
            end else begin
                cand_d    = frame_res;
                deb_cnt_d = DEB_W'(1);
            end
            if (deb_cnt_d == DEB_MAX) stable_d = cand_d;
            ready_d   = (stable_d.kind == K_SINGLE);
            keycode_d = ready_d ? stable_d.code : 5'd0;
            press_d   = ready_d && (stable_d != stable_q);
        end
    end

    assign col_n   = col_n_q;
    assign keycode = keycode_q;
    assign ready   = ready_q;
    assign press   = press_q;
endmodule
